mult_issue_ctrl: RTL and testbench
==================================

Name: mult_issue_ctrl

Overview:
- Upstream issue and downstream capture controller for the iterative signed shift-add multiplier (the integrationSignedShiftMultiplier core).
- Accepts operand pairs over a valid/ready handshake and latches them. It pulses the core's reset, holds the operands stable for the core's fixed iteration latency, then captures the product.
- Presents the product on a valid/ready output.
- Replaces the open-loop "apply operands, wait N cycles" usage of the core with a flow-controlled interface.

Parameters:
- WIDTH, 32, operand width in bits; product width is 2*WIDTH.
- LATENCY, 64, clock cycles from mul_reset deassertion until mul_z is final; must be >= 1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept an operand pair.
- in_x  in  WIDTH  signed multiplicand.
- in_y  in  WIDTH  signed multiplier.
- mul_reset  out  1  reset to the multiplier core.
- mul_en  out  1  enable to the multiplier core.
- mul_x  out  WIDTH  operand X to the core.
- mul_y  out  WIDTH  operand Y to the core.
- mul_z  in  2*WIDTH  product from the core.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- out_z  out  2*WIDTH  signed product.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_z=0, mul_x=0, mul_y=0, mul_en=0, mul_reset=1, busy=0, counter=0.
- States: IDLE, CLEAR, RUN, HOLD.
- IDLE:
  - in_ready=1, mul_reset=1, mul_en=0.
  - On in_valid&&in_ready, latch in_x/in_y into mul_x/mul_y and go to CLEAR.
- CLEAR (exactly 1 cycle):
  - mul_reset=1, mul_en=1, operands stable.
  - Load counter=LATENCY-1, then go to RUN.
- RUN:
  - mul_reset=0, mul_en=1; mul_x/mul_y must not change.
  - Counter decrements each cycle.
  - At counter==0, capture out_z<=mul_z, set out_valid=1, go to HOLD.
- HOLD:
  - mul_en=0, mul_reset=0, out_z held.
  - On out_valid&&out_ready, clear out_valid.
  - In the same cycle, in_ready=1 (combinational: in_ready = IDLE || (HOLD && out_ready)). If in_valid is also high, latch new operands and go directly to CLEAR (back-to-back, zero bubble); otherwise go to IDLE.
- Latency: input handshake to out_valid is LATENCY+2 cycles (1 latch + 1 CLEAR + LATENCY RUN).
- Throughput: one result per LATENCY+2 cycles under no backpressure.
- in_ready=0 in CLEAR and RUN; in_valid there is ignored and must be held by the source.
- out_valid stays high with out_z stable until accepted; it never drops without a handshake.
- Arithmetic: out_z is the core's product unmodified, two's complement, 2*WIDTH bits. The controller does no sign handling.
- Reset mid-operation (any state): returns to IDLE next edge. The in-flight operation and any unaccepted result are discarded; mul_reset is asserted.
- Counter width: $clog2(LATENCY+1).

Optional Feature:
- Macro: MULT_ISSUE_ZERO_BYPASS_EN.
- Defined: in IDLE or at the HOLD re-issue point, if the accepted in_x==0 or in_y==0, skip CLEAR/RUN. Next cycle out_valid=1 with out_z=0 (latency 1), and the core stays in reset. Bypassed results obey the same HOLD handshake.
- Undefined: zero operands take the full LATENCY+2 path like any other pair.

Decomposition:
- Shared package mult_pkg: state enum (IDLE, CLEAR, RUN, HOLD), default WIDTH=32, default LATENCY=64, product-width function 2*WIDTH.
- One natural sub-module: mult_latency_counter (load, decrement, zero flag).
- The multiplier core is instantiated by the parent, not inside this block.

Test Plan:
- Single op: x=2, y=4, out_ready=1 -> out_valid rises exactly 66 cycles after the input handshake; out_z=64'd8.
- Signed: x=-2, y=4 -> out_z=64'hFFFF_FFFF_FFFF_FFF8; x=-7, y=-4 -> 64'd28; x=2, y=-3 -> 64'hFFFF_FFFF_FFFF_FFFA.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_z stable, in_ready=0 throughout; release -> one handshake; in_valid held high is accepted in the same cycle.
- Back-to-back: stream (524290, 67108868) then (1, 67108868) -> out_z=35184508403720 then 67108868, second out_valid 66 cycles after the first acceptance.
- Reset mid-RUN: assert reset 20 cycles into RUN -> next cycle state=IDLE, out_valid=0, mul_reset=1, in_ready=1; no stale result appears.
- Zero operand: x=0, y=67108868 -> out_z=0; with MULT_ISSUE_ZERO_BYPASS_EN at 1 cycle, without it at 66 cycles.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and defaults for the shift-add multiplier issue controller.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam int unsigned DEFAULT_WIDTH   = 32;
  localparam int unsigned DEFAULT_LATENCY = 64;

  // Product of two WIDTH-bit operands is twice as wide.
  function automatic int unsigned prod_width(input int unsigned width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/mult_latency_counter.sv
// Down-counter timing the multiplier core's iteration window.
module mult_latency_counter #(
  parameter int unsigned CW = 7
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_value,
  output logic          zero_c
);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/mult_issue_ctrl.sv
// Flow-controlled issue/capture wrapper around the iterative signed shift-add multiplier.
// Optional zero-operand bypass enabled by defining MULT_ISSUE_ZERO_BYPASS_EN.
module mult_issue_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH   = DEFAULT_WIDTH,
  parameter int unsigned LATENCY = DEFAULT_LATENCY
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_x,
  input  logic [WIDTH-1:0]             in_y,
  output logic                         mul_reset,
  output logic                         mul_en,
  output logic [WIDTH-1:0]             mul_x,
  output logic [WIDTH-1:0]             mul_y,
  input  logic [prod_width(WIDTH)-1:0] mul_z,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [prod_width(WIDTH)-1:0] out_z,
  output logic                         busy
);

  localparam int unsigned CW = $clog2(LATENCY + 1);

  state_e state;
  logic   accept_c;
  logic   bypass_c;
  logic   cnt_zero_c;

  // A result sitting in HOLD can be retired and replaced in the same cycle.
  assign in_ready = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept_c = in_valid && in_ready;

`ifdef MULT_ISSUE_ZERO_BYPASS_EN
  assign bypass_c = (in_x == '0) || (in_y == '0);
`else
  assign bypass_c = 1'b0;
`endif

  mult_latency_counter #(
    .CW (CW)
  ) u_latency_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (state == CLEAR),
    .dec        (state == RUN),
    .load_value (CW'(LATENCY - 1)),
    .zero_c     (cnt_zero_c)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_z     <= '0;
      mul_x     <= '0;
      mul_y     <= '0;
      mul_en    <= 1'b0;
      mul_reset <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE, HOLD: begin
          if ((state == HOLD) && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
            busy      <= 1'b0;
            mul_reset <= 1'b1;
            mul_en    <= 1'b0;
          end
          // Issue overrides the retire above when a new pair arrives.
          if (accept_c) begin
            mul_x <= in_x;
            mul_y <= in_y;
            busy  <= 1'b1;
            if (bypass_c) begin
              state     <= HOLD;
              out_valid <= 1'b1;
              out_z     <= '0;
              mul_reset <= 1'b1;
              mul_en    <= 1'b0;
            end else begin
              state     <= CLEAR;
              mul_reset <= 1'b1;
              mul_en    <= 1'b1;
            end
          end
        end
        CLEAR: begin
          state     <= RUN;
          mul_reset <= 1'b0;
          mul_en    <= 1'b1;
        end
        RUN: begin
          if (cnt_zero_c) begin
            out_z     <= mul_z;
            out_valid <= 1'b1;
            state     <= HOLD;
            mul_en    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Scoreboard bench for mult_issue_ctrl with a cycle-accurate behavioural multiplier core.
module tb_mult_issue_ctrl;

  localparam int WIDTH = 32;
  localparam int LAT   = 64;
  localparam int FULL  = LAT + 2;
`ifdef MULT_ISSUE_ZERO_BYPASS_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = FULL;
`endif

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_x, in_y;
  logic                 mul_reset, mul_en;
  logic [WIDTH-1:0]     mul_x, mul_y;
  logic [2*WIDTH-1:0]   mul_z;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_z;
  logic                 busy;

  typedef struct {
    logic [63:0] z;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   hs_q[$];
  int   vec  = 0;
  int   miss = 0;
  int   cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mult_issue_ctrl #(.WIDTH(WIDTH), .LATENCY(LAT)) dut (
    .clock     (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .mul_reset (mul_reset),
    .mul_en    (mul_en),
    .mul_x     (mul_x),
    .mul_y     (mul_y),
    .mul_z     (mul_z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_z     (out_z),
    .busy      (busy)
  );

  // Core model: product is only correct once LAT-1 enabled edges have passed since reset.
  logic signed [63:0] sx, sy, prod;
  int core_cnt;
  assign sx    = {{32{mul_x[31]}}, mul_x};
  assign sy    = {{32{mul_y[31]}}, mul_y};
  assign prod  = sx * sy;
  assign mul_z = (core_cnt >= LAT - 1) ? prod : ~prod;

  always_ff @(posedge clk) begin
    if (mul_reset)   core_cnt <= 0;
    else if (mul_en) core_cnt <= core_cnt + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: timestamps input handshakes, checks latency and product of each result.
  logic ov_q = 1'b0, acc_q = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      hs_q.delete();
      ov_q  = 1'b0;
      acc_q = 1'b0;
    end else begin
      if (in_valid && in_ready) hs_q.push_back(cyc);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          vec++;
          miss++;
          $display("FAIL stale_result: got out_z %h with nothing expected", out_z);
        end else begin
          if (!ov_q || acc_q) begin
            int l;
            l = (hs_q.size() != 0) ? cyc - hs_q.pop_front() : -1;
            chk("latency", 64'(l), 64'(exp_q[0].lat));
          end
          chk("out_z", out_z, exp_q[0].z);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      ov_q  = out_valid;
      acc_q = out_valid && out_ready;
    end
  end

  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [63:0] z,
                      input int lat, input bit push);
    int n;
    if (push) exp_q.push_back('{z: z, lat: lat});
    in_x = x;
    in_y = y;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 2000);
    if (!in_ready) chk("send_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_z",     out_z,          64'd0);
    chk("rst_mul_x",     64'(mul_x),     64'd0);
    chk("rst_mul_y",     64'(mul_y),     64'd0);
    chk("rst_mul_en",    64'(mul_en),    64'd0);
    chk("rst_mul_reset", 64'(mul_reset), 64'd1);
    chk("rst_busy",      64'(busy),      64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single op and signed cases
    send(32'd2, 32'd4, 64'd8, FULL, 1'b1);
    drain();
    send(32'hFFFF_FFFE, 32'd4, 64'hFFFF_FFFF_FFFF_FFF8, FULL, 1'b1);
    drain();
    send(32'hFFFF_FFF9, 32'hFFFF_FFFC, 64'd28, FULL, 1'b1);
    drain();
    send(32'd2, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFA, FULL, 1'b1);
    drain();

    // Backpressure, then a held in_valid accepted on release
    out_ready = 1'b0;
    send(32'd3, 32'd5, 64'd15, FULL, 1'b1);
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_valid_seen", 64'(out_valid), 64'd1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready",  64'(in_ready),  64'd0);
      chk("bp_out_z",     out_z,          64'd15);
    end
    fork
      send(32'd6, 32'd7, 64'd42, FULL, 1'b1);
      begin
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);
      end
    join
    drain();

    // Back-to-back stream
    send(32'd524290, 32'd67108868, 64'd35184508403720, FULL, 1'b1);
    send(32'd1, 32'd67108868, 64'd67108868, FULL, 1'b1);
    drain();

    // Reset 20 cycles into RUN discards the operation
    send(32'd5, 32'd9, 64'd0, 0, 1'b0);
    @(posedge clk);
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_mul_reset", 64'(mul_reset), 64'd1);
    chk("midrst_in_ready",  64'(in_ready),  64'd1);
    chk("midrst_busy",      64'(busy),      64'd0);
    repeat (80) @(negedge clk);
    chk("midrst_no_stale",  64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Zero operand
    send(32'd0, 32'd67108868, 64'd0, ZLAT, 1'b1);
    drain();
    send(32'd7, 32'd3, 64'd21, FULL, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
